// File: rtl/calc_pkg.sv
// Shared encodings for the N-bit load-and-add calculator: FSM states, op codes
// and the state-indicator LED mapping.
package calc_pkg;

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_A     = 3'd1,
    S_B     = 3'd2,
    S_READY = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // {READY|DONE, B loaded, A loaded}
  function automatic logic [2:0] stateLeds(input state_t s);
    logic [2:0] leds;
    leds = 3'b000;
    case (s)
      S_A:             leds = 3'b001;
      S_B:             leds = 3'b010;
      S_READY, S_DONE: leds = 3'b111;
      default:         leds = 3'b000;
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Raw button -> synchroniser chain -> saturating debounce counter -> single
// registered pulse per press; a release is needed before the next pulse.
module btn_pulse #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] syncQ;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced = syncQ[SYNC_STAGES-1];

  // Pulse fires on the edge where the count reaches its limit; saturation blocks repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncQ <= '0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], btn_raw};
      pulse <= synced && (cnt == CNT_LAST);
      if (!synced) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/calc_nbit_core.sv
// Parametrised load-and-compute calculator: captures two operands on debounced
// button presses and drives a registered ADD/SUB/AND/OR result to the LEDs.
module calc_nbit_core #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             btnLoadA,
  input  logic             btnLoadB,
  input  logic [1:0]       op_sel,
  output logic [WIDTH:0]   led_out,
  output logic             result_valid,
  output logic [2:0]       state_led
);

  import calc_pkg::*;

  localparam int unsigned RW = WIDTH + 1;

  logic          pulseA;
  logic          pulseB;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [1:0]    opUsed;
  logic [1:0]    opNext;
  logic [RW-1:0] aluRes;
  logic [RW-1:0] ledNext;
  logic          validNext;
  state_t        state;
  state_t        stateNext;

  btn_pulse #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uBtnA (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btnLoadA),
    .pulse  (pulseA)
  );

  btn_pulse #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uBtnB (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btnLoadB),
    .pulse  (pulseB)
  );

  // Zero-extending to RW bits makes the top bit carry for ADD and borrow for SUB.
  always_comb begin
    aluRes = '0;
    case (op_sel)
      OP_ADD:  aluRes = {1'b0, regA} + {1'b0, regB};
      OP_SUB:  aluRes = {1'b0, regA} - {1'b0, regB};
      OP_AND:  aluRes = {1'b0, regA & regB};
      OP_OR:   aluRes = {1'b0, regA | regB};
      default: aluRes = '0;
    endcase
  end

  always_comb begin
    stateNext = state;
    ledNext   = led_out;
    validNext = 1'b0;
    opNext    = opUsed;
    case (state)
      S_EMPTY: begin
        if (pulseA && pulseB) stateNext = S_READY;
        else if (pulseA)      stateNext = S_A;
        else if (pulseB)      stateNext = S_B;
      end
      S_A: if (pulseB) stateNext = S_READY;
      S_B: if (pulseA) stateNext = S_READY;
      S_READY: begin
        stateNext = S_DONE;
        ledNext   = aluRes;
        validNext = 1'b1;
        opNext    = op_sel;
      end
      S_DONE: begin
        // Any new operand or a different op invalidates the shown result.
        validNext = 1'b1;
        if (pulseA || pulseB || (op_sel != opUsed)) begin
          stateNext = S_READY;
          validNext = 1'b0;
        end
      end
      default: stateNext = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_EMPTY;
      regA         <= '0;
      regB         <= '0;
      opUsed       <= OP_ADD;
      led_out      <= '0;
      result_valid <= 1'b0;
      state_led    <= 3'b000;
    end else begin
      state        <= stateNext;
      regA         <= pulseA ? inA : regA;
      regB         <= pulseB ? inB : regB;
      opUsed       <= opNext;
      led_out      <= ledNext;
      result_valid <= validNext;
      state_led    <= stateLeds(stateNext);
    end
  end

endmodule
